// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg -- shared definitions for the mem_ctrl request/response
// memory controller.
//   state_t          : controller FSM state encoding
//   *_DEF localparams: default values for the mem_ctrl parameters
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int MEM_DEPTH_DEF = 200;
  localparam int READ_LAT_DEF  = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl -- single-outstanding memory controller between a core
// request/response channel and a synchronous memory whose read data is
// registered inside the memory.
//
// Optional feature: define MEM_CTRL_BOUNDS_CHECK_EN to reject requests whose
// address is >= MEM_DEPTH (no memory access, rsp_err=1, rsp_data=0).
//
// Ports
//   clk, reset            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (req_write, req_adress, req_data)
//   rsp_valid/rsp_ready   : response handshake (rsp_data, rsp_err)
//   adress, data          : memory address / write data (held between accesses)
//   memRead, memWrite     : memory read / write enables
//   memOut                : memory read data (registered inside the memory)
//   busy                  : high whenever the FSM is not in IDLE
//   fsm_state             : current FSM state, for observation
//
// Handshakes: a transfer happens on the rising clk edge where valid and
// ready are both high. req_ready is high only in IDLE, so at most one request
// is ever outstanding; rsp_valid is high only in RESP, and rsp_data/rsp_err
// stay constant there until rsp_ready is seen.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int READ_LAT  = READ_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_adress,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] adress,
  output logic [DATA_W-1:0] data,
  output logic              memRead,
  output logic              memWrite,
  input  logic [DATA_W-1:0] memOut,
  output logic              busy,
  output state_t            fsm_state
);

  if (READ_LAT < 1 || READ_LAT > 7 || MEM_DEPTH < 1) begin : g_param_err
    $error("mem_ctrl: READ_LAT must be 1..7 and MEM_DEPTH must be >= 1");
  end

  // READ lasts READ_LAT cycles: the counter is loaded with READ_LAT-1 at
  // acceptance and READ exits on the cycle where it reads zero.
  localparam logic [2:0] CNT_INIT = 3'(READ_LAT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] adress_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [2:0]        cnt_q;
  logic              accept;
  logic              in_range;

  assign accept = req_valid && (state_q == IDLE);

`ifdef MEM_CTRL_BOUNDS_CHECK_EN
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);
  logic err_q;
  assign in_range = (req_adress < DEPTH_A);
  // err_q is only meaningful in RESP; gating keeps rsp_err low elsewhere.
  assign rsp_err  = err_q && (state_q == RESP);
`else
  assign in_range = 1'b1;
  assign rsp_err  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!in_range)      state_d = RESP;
          else if (req_write) state_d = WRITE;
          else                state_d = READ;
        end
      end
      WRITE:   state_d = RESP;
      READ:    if (cnt_q == 3'd0) state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      adress_q   <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      cnt_q      <= '0;
`ifdef MEM_CTRL_BOUNDS_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        adress_q   <= req_adress;
        data_q     <= req_data;
        // Writes and rejected requests answer with zero data.
        rsp_data_q <= '0;
        cnt_q      <= CNT_INIT;
`ifdef MEM_CTRL_BOUNDS_CHECK_EN
        err_q      <= !in_range;
`endif
      end
      if (state_q == READ && cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
      // Memory data is valid during CAPTURE because the memory registers it
      // on the last READ edge.
      if (state_q == CAPTURE) rsp_data_q <= memOut;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign memRead   = (state_q == READ);
  assign memWrite  = (state_q == WRITE);
  assign adress    = adress_q;
  assign data      = data_q;
  assign rsp_data  = rsp_data_q;
  assign fsm_state = state_q;

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter MEM_DEPTH, default 200, number of valid words in the attached memory.
REQ-004 Parameter READ_LAT, default 1, range 1..7, cycles memRead is held before sampling memOut.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  1  core request present.
REQ-008 req_ready  out  1  controller can accept a request.
REQ-009 req_write  in  1  1 = write, 0 = read.
REQ-010 req_adress  in  ADDR_W  word address.
REQ-011 req_data  in  DATA_W  write data.
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  core accepts the response.
REQ-014 rsp_data  out  DATA_W  read data; 0 for writes and errors.
REQ-015 rsp_err  out  1  access rejected (out of range).
REQ-016 adress  out  ADDR_W  memory address.
REQ-017 data  out  DATA_W  memory write data.
REQ-018 memRead  out  1  memory read enable.
REQ-019 memWrite  out  1  memory write enable.
REQ-020 memOut  in  DATA_W  memory read data, registered inside the memory.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 FSM states IDLE, WRITE, READ, CAPTURE, RESP; all outputs decoded from registered state and capture registers only.
REQ-023 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid && req_ready, latching req_write, req_adress and req_data.
REQ-024 Accepted write: IDLE->WRITE; WRITE lasts exactly 1 cycle with memWrite=1, adress and data driven from the latches; then WRITE->RESP with rsp_data=0.
REQ-025 Accepted read: IDLE->READ; READ lasts READ_LAT cycles with memRead=1, held by a 3-bit down-counter; then READ->CAPTURE.
REQ-026 CAPTURE lasts 1 cycle with memRead=0; memOut is registered into rsp_data on its closing edge; CAPTURE->RESP.
REQ-027 With READ_LAT=1, rsp_valid SHALL rise 3 cycles after the acceptance edge for reads and 2 cycles after it for writes.
REQ-028 RESP drives rsp_valid=1; rsp_data and rsp_err stay stable until rsp_valid && rsp_ready, then RESP->IDLE.
REQ-029 Only one request is outstanding; req_valid outside IDLE is ignored and not queued.
REQ-030 memRead and memWrite SHALL never be high together, and both are 0 outside READ and WRITE.
REQ-031 adress and data hold their last latched values in non-access states.
REQ-032 rsp_ready held high in RESP gives a 1-cycle rsp_valid pulse; a new request is accepted no earlier than the cycle after returning to IDLE.

Reset
REQ-033 reset low SHALL immediately force IDLE; req_ready=1 once reset is released; rsp_valid, rsp_err, memRead, memWrite, busy=0; rsp_data, adress, data, counter=0.
REQ-034 Reset mid-operation abandons the transaction with no response; a write whose WRITE-cycle edge did not complete before reset asserted is not issued.

Configuration
REQ-035 With MEM_CTRL_BOUNDS_CHECK_EN defined, a request with req_adress >= MEM_DEPTH SHALL go IDLE->RESP directly, with no memRead/memWrite, rsp_err=1 and rsp_data=0.
REQ-036 Without MEM_CTRL_BOUNDS_CHECK_EN, no range check exists, rsp_err is tied 0, and all addresses are forwarded.

Structure
REQ-037 Shared package mem_ctrl_pkg holds the state enum and the parameter defaults (ADDR_W, DATA_W, MEM_DEPTH, READ_LAT).
REQ-038 There is no sub-module; the latency counter is inline.

Verification
REQ-039 Write addr 105 data 5, rsp_ready=1 -> memWrite high for exactly 1 cycle with adress=105, data=5; rsp_valid 2 cycles after acceptance, rsp_data=0, rsp_err=0.
REQ-040 Memory preloaded word 106=4, read 106, READ_LAT=1 -> memRead high for 1 cycle; rsp_valid 3 cycles after acceptance with rsp_data=4.
REQ-041 READ_LAT=3, read 105 holding 5 -> memRead high for 3 cycles; rsp_data=5; rsp_ready held 0 for 4 cycles -> response stable throughout, req_ready=0.
REQ-042 Bounds-check enabled, read 250 -> no memRead, rsp_err=1, rsp_data=0; macro undefined -> memRead asserted with adress=250 and rsp_err=0.
REQ-043 reset asserted during READ -> memRead and busy drop immediately, no rsp_valid; the next read of 105 returns 5.
REQ-044 req_valid held high for back-to-back write 107 then read 107 -> second request accepted only after the first response handshake; read returns the written value.
